// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, parity constants, prescaler decode.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Prescaler field value 0 stands for 32 cycles per bit.
  function automatic logic [5:0] prescale_decode(input logic [4:0] prescaler);
    return (prescaler == 5'd0) ? 6'd32 : {1'b0, prescaler};
  endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit timing for the transmitter: edge counter 0..n-1 and per-state bit counter.
module uart_tx_baud_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [5:0]       n,
  output logic             bit_tick,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [5:0]       edge_q, edge_d;
  logic [CNT_W-1:0] bit_q, bit_d;

  assign bit_tick = enable && (edge_q == (n - 6'd1));
  assign bit_cnt  = bit_q;

  // Next-count logic: clear wins, otherwise advance while enabled.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clear) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (enable) begin
      if (bit_tick) begin
        edge_d = '0;
        bit_d  = bit_q + CNT_W'(1);
      end else begin
        edge_d = edge_q + 6'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// Build option UART_TX_TWO_STOP_EN: two stop bits instead of one.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned Data_Width = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_Width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            Prescaler,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned CNT_W = 4;

  tx_state_e             state_q, state_d;
  logic [Data_Width-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            n_q, n_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  cnt_en, cnt_clr, bit_tick, stop_last;
  logic [CNT_W-1:0]      bit_cnt, bit_idx;
  logic                  data_bit, parity_bit;

  uart_tx_baud_cnt #(
    .CNT_W (CNT_W)
  ) u_baud_cnt (
    .clk      (CLK),
    .rst_n    (RST),
    .enable   (cnt_en),
    .clear    (cnt_clr),
    .n        (n_q),
    .bit_tick (bit_tick),
    .bit_cnt  (bit_cnt)
  );

`ifdef UART_TX_TWO_STOP_EN
  assign stop_last = (bit_cnt == CNT_W'(1));
`else
  assign stop_last = 1'b1;
`endif

  assign parity_bit = (^data_q) ^ (par_typ_q == PAR_ODD);

  // Next state, frame latching and registered line value.
  // TX_OUT is registered, so the line value is derived from the next state
  // and the bit index that will be current after this edge.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    n_d       = n_q;
    tx_d      = 1'b1;
    bit_idx   = '0;
    data_bit  = 1'b1;

    unique case (state_q)
      TX_IDLE: begin
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          n_d       = prescale_decode(Prescaler);
          state_d   = TX_START;
        end
      end
      TX_START: if (bit_tick) state_d = TX_DATA;
      TX_DATA: begin
        if (bit_tick && (bit_cnt == CNT_W'(Data_Width - 1)))
          state_d = par_en_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (bit_tick) state_d = TX_STOP;
      TX_STOP: if (bit_tick && stop_last) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase

    cnt_en  = (state_q != TX_IDLE);
    cnt_clr = (state_q == TX_IDLE) || (state_d != state_q);

    if ((state_q == TX_DATA) && (state_d == TX_DATA))
      bit_idx = bit_tick ? (bit_cnt + CNT_W'(1)) : bit_cnt;

    for (int unsigned i = 0; i < Data_Width; i++)
      if (bit_idx == CNT_W'(i)) data_bit = data_q[i];

    unique case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = data_bit;
      TX_PARITY: tx_d = parity_bit;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != TX_IDLE);
  end

  // State, frame and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= TX_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      n_q       <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      n_q       <= n_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus random traffic,
// line checked cycle by cycle against a frame built from the framing rules,
// and decoded by mid-bit sampling as a receiver would.
module tb_uart_tx;
  import uart_pkg::*;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [4:0] Prescaler = 5'd8;
  logic       TX_OUT;
  logic       Busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  uart_tx #(.Data_Width(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescaler  (Prescaler),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after the accept edge.
  task automatic request(input logic [7:0] d, input logic pen, input logic ptyp,
                         input logic [4:0] ps);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Prescaler  = ps;
    Data_Valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Check a whole frame cycle by cycle, then the first idle cycle.
  task automatic check_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic [4:0] ps, input int glitch_at,
                             input bit keep_dv, input logic [7:0] next_d,
                             input int abort_at);
    int   n;
    int   f;
    logic line[$];
    logic samp[$];
    logic [7:0] rx;
    n = (ps == 5'd0) ? 32 : int'(ps);
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(d[i]);
    if (pen) line.push_back((($countones(d) % 2) == 1) ^ ptyp);
    for (int i = 0; i < STOP_BITS; i++) line.push_back(1'b1);
    f = n * line.size();

    if (keep_dv) P_DATA = next_d;
    else         Data_Valid = 1'b0;

    for (int k = 0; k < f; k++) begin
      check("line", 32'(TX_OUT), 32'(line[k / n]));
      check("busy", 32'(Busy), 32'd1);
      if ((k % n) == (n / 2)) samp.push_back(TX_OUT);
      if (k == abort_at) begin
        #2 RST = 1'b0;
        #1;
        check("rst_line", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        Data_Valid = 1'b0;
        @(negedge CLK);
        check("rst_hold_line", 32'(TX_OUT), 32'd1);
        check("rst_hold_busy", 32'(Busy), 32'd0);
        RST = 1'b1;
        return;
      end
      if (k == glitch_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = ~pen;
        PAR_TYP    = ~ptyp;
        Prescaler  = 5'd5;
      end else if (glitch_at >= 0 && k == glitch_at + 1) begin
        Data_Valid = 1'b0;
      end
      @(negedge CLK);
    end

    check("idle_line", 32'(TX_OUT), 32'd1);
    check("idle_busy", 32'(Busy), 32'd0);

    for (int i = 0; i < 8; i++) rx[i] = samp[1 + i];
    check("rx_data", 32'(rx), 32'(d));
    if (pen) check("rx_parity", 32'(^{samp[9], rx}), 32'(ptyp));
    for (int s = 0; s < STOP_BITS; s++)
      check("rx_stop", 32'(samp[samp.size() - 1 - s]), 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rpen, rptyp;
    logic [4:0] rps;

    repeat (3) @(negedge CLK);
    check("reset_line", 32'(TX_OUT), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_after_reset", 32'(TX_OUT), 32'd1);

    request(8'hA5, 1'b1, PAR_EVEN, 5'd8);
    check_frame(8'hA5, 1'b1, PAR_EVEN, 5'd8, -1, 1'b0, 8'h00, -1);

    request(8'hA5, 1'b1, PAR_ODD, 5'd16);
    check_frame(8'hA5, 1'b1, PAR_ODD, 5'd16, -1, 1'b0, 8'h00, -1);

    request(8'h3C, 1'b0, PAR_EVEN, 5'd0);
    check_frame(8'h3C, 1'b0, PAR_EVEN, 5'd0, 150, 1'b0, 8'h00, -1);

    // Back-to-back with Data_Valid held: exactly one idle cycle between frames.
    request(8'h01, 1'b0, PAR_EVEN, 5'd8);
    check_frame(8'h01, 1'b0, PAR_EVEN, 5'd8, -1, 1'b1, 8'h80, -1);
    @(posedge CLK);
    @(negedge CLK);
    check_frame(8'h80, 1'b0, PAR_EVEN, 5'd8, -1, 1'b0, 8'h00, -1);

    // Reset mid-frame, then a clean frame.
    request(8'h96, 1'b1, PAR_EVEN, 5'd8);
    check_frame(8'h96, 1'b1, PAR_EVEN, 5'd8, -1, 1'b0, 8'h00, 40);
    @(negedge CLK);
    check("post_reset_idle", 32'(TX_OUT), 32'd1);
    request(8'h55, 1'b0, PAR_EVEN, 5'd8);
    check_frame(8'h55, 1'b0, PAR_EVEN, 5'd8, -1, 1'b0, 8'h00, -1);

    // Random traffic.
    for (int t = 0; t < 200; t++) begin
      rd    = 8'($urandom_range(0, 255));
      rpen  = 1'($urandom_range(0, 1));
      rptyp = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       rps = 5'd8;
        1:       rps = 5'd16;
        default: rps = 5'd0;
      endcase
      request(rd, rpen, rptyp, rps);
      check_frame(rd, rpen, rptyp, rps, -1, 1'b0, 8'h00, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serializes a parallel byte into a framed line: start bit, LSB-first data, optional parity, and stop bit. It is the upstream counterpart of the UART receiver and drives the line the receiver samples. It runs on the same oversampled clock as the receiver and uses the same Prescaler encoding, so a single clock domain serves both directions and loopback tests work directly.

Parameters:
- Data_Width, default 8, number of data bits per frame (legal range 5..9).

Ports:
- CLK         input   1           single system clock (oversampled, same as RX)
- RST         input   1           asynchronous, active-low reset
- P_DATA      input   Data_Width  parallel data to send
- Data_Valid  input   1           request; P_DATA is valid this cycle
- PAR_EN      input   1           1 = insert parity bit
- PAR_TYP     input   1           0 = even parity, 1 = odd parity
- Prescaler   input   5           CLK cycles per bit; 0 encodes 32
- TX_OUT      output  1           serial line, idle high
- Busy        output  1           frame in progress; request not accepted

Behaviour:
- Reset (RST low, asynchronous):
  - TX_OUT=1, Busy=0, FSM in IDLE, all counters 0, data register 0.
  - Reset mid-frame aborts the frame immediately; the line returns high.
- Accept: on a rising CLK where Data_Valid=1 and the FSM is in IDLE, the block latches P_DATA, PAR_EN, PAR_TYP and Prescaler.
  - Latched values are used for the whole frame; input changes mid-frame have no effect.
- Data_Valid while Busy=1 is ignored; there is no queueing and no error flag.
- Latency: on the edge after accept, Busy=1 and TX_OUT=0 (start bit begins). One-cycle registered latency.
- Bit period: each bit is held for exactly N CLK cycles, with N = Prescaler (0 → 32).
  - Prescaler values 1..3 are illegal; behaviour is unspecified and the bench avoids them.
  - An edge counter runs 0..N-1; a bit advance happens when the counter reaches N-1.
- FSM states: IDLE → START → DATA → (PARITY if PAR_EN) → STOP → IDLE.
  - START: TX_OUT=0 for N cycles.
  - DATA: TX_OUT = data[bit_cnt], with bit_cnt running 0..Data_Width-1, LSB first. DATA exits after bit Data_Width-1 has been held for N cycles.
  - PARITY: TX_OUT = (XOR of latched data) XOR PAR_TYP, i.e. even makes the total ones count even.
  - STOP: TX_OUT=1 for N cycles (2N with the optional feature).
  - IDLE: TX_OUT=1.
- Busy is 1 in every state except IDLE.
- Busy falls on the edge that enters IDLE. The earliest next accept is that same IDLE cycle, so the minimum inter-frame gap is 1 CLK of idle-high line.
- Frame length in CLK cycles = N × (1 + Data_Width + PAR_EN + stop_bits).
- TX_OUT is driven directly from a register (glitch-free); no combinational path from inputs to TX_OUT.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- When defined: STOP holds TX_OUT=1 for 2N cycles (two stop bits), and Busy is extended accordingly.
- When undefined: exactly one stop bit of N cycles.
- Port list is identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - the TX FSM state encoding (IDLE, START, DATA, PARITY, STOP; 3-bit);
  - parity type constants PAR_EVEN=0 and PAR_ODD=1;
  - the Prescaler zero-means-32 decode function;
  - the default data width constant.
  The RX side reuses the parity and prescaler definitions.
- One sub-module, uart_tx_baud_cnt, holds the edge counter (0..N-1) and the bit counter.
  - Inputs: enable, clear, decoded N.
  - Outputs: bit_tick, bit_cnt.
- The FSM, data/parity registers and output mux stay in uart_tx.

Test Plan:
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescaler=8:
  - line = 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit 8 cycles;
  - Busy high for exactly 88 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=1, Prescaler=16: parity bit = 1; frame = 176 cycles.
- P_DATA=0x3C, PAR_EN=0, Prescaler=0 (32):
  - no parity bit; 10 bits × 32 = 320 cycles;
  - Data_Valid=1 with P_DATA=0xFF pulsed mid-frame is ignored, and the line still carries 0x3C.
- Back-to-back: Data_Valid held high with 0x01 then 0x80 → two frames separated by exactly 1 idle-high cycle, second data correct.
- Assert RST at cycle 40 of a Prescaler=8 frame:
  - TX_OUT=1 and Busy=0 immediately (asynchronous);
  - after release, a new 0x55 request transmits a clean frame.
- Loopback TX_OUT → UART_RX RX_IN, 200 random bytes, random PAR_EN/PAR_TYP matched on both sides, Prescaler ∈ {8,16,32}:
  - every RX P_Data matches the sent byte;
  - Data_Valid pulses once per frame;
  - no parity or stop errors.
  - With UART_TX_TWO_STOP_EN defined: frame length grows by N cycles and RX still passes.
